// File: rtl/inst_queue.sv
// Instruction queue between fetch and issue.
// Circular FIFO of {inst, pc} pairs with combinational decode of the head entry.
//
// Handshakes:
//   push side: a word is taken on a rising edge when inst_valid=1, rdy=1,
//              jump_flag=0 and either queue_full=0 or the head leaves on that
//              same edge; otherwise the word is dropped.
//   pop side:  the head leaves on a rising edge when out_valid=1 and
//              issue_ready=1 (with rdy=1 and jump_flag=0).
//   rdy=0 freezes everything; jump_flag=1 empties the queue and overrides both.
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        inst_valid,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  output logic        queue_full,
  input  logic        jump_flag,
  input  logic        issue_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic [31:0] out_imm
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;

  logic        do_pop;
  logic        do_push;
  logic        do_flush;
  logic [31:0] head_inst;
  logic [31:0] head_pc;

  assign out_valid  = (count != '0);
  assign queue_full = (count == DEPTH_CNT);

  assign do_flush = rdy & jump_flag;
  assign do_pop   = rdy & ~jump_flag & out_valid & issue_ready;
  assign do_push  = rdy & ~jump_flag & inst_valid & (~queue_full | do_pop);

  // Pointer and occupancy state; a flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (do_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_pop)  head <= head + 1'b1;
      if (do_push) tail <= tail + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      inst_mem[tail] <= inst_in;
      pc_mem[tail]   <= pc_in;
    end
  end

  // Head entry, forced to zero when the queue is empty.
  always_comb begin
    head_inst = '0;
    head_pc   = '0;
    if (out_valid) begin
      head_inst = inst_mem[head];
      head_pc   = pc_mem[head];
    end
  end

  assign out_inst   = head_inst;
  assign out_pc     = head_pc;
  assign out_opcode = head_inst[6:0];
  assign out_rd     = head_inst[11:7];
  assign out_rs1    = head_inst[19:15];
  assign out_rs2    = head_inst[24:20];
  assign out_funct3 = head_inst[14:12];

  // Immediate extraction selected by the head opcode.
  always_comb begin
    out_imm = '0;
    case (head_inst[6:0])
      OP_LUI, OP_AUIPC:
        out_imm = {head_inst[31:12], 12'b0};
      OP_JAL:
        out_imm = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20],
                   head_inst[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_IMM:
        out_imm = {{20{head_inst[31]}}, head_inst[31:20]};
      OP_BRANCH:
        out_imm = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25],
                   head_inst[11:8], 1'b0};
      OP_STORE:
        out_imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
      default:
        out_imm = '0;
    endcase
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: queue-based reference model compared on
// every falling edge, plus literal expectations at key points.
module tb_inst_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        inst_valid;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        queue_full;
  logic        jump_flag;
  logic        issue_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [31:0] out_imm;

  int total = 0;
  int bad   = 0;
  logic checking = 1'b0;

  // Reference model: each element is {inst, pc}.
  logic [63:0] mq[$];

  inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .inst_valid(inst_valid), .inst_in(inst_in), .pc_in(pc_in),
    .queue_full(queue_full), .jump_flag(jump_flag), .issue_ready(issue_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_imm(out_imm)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate worked out from the ISA field layout using signed shifts.
  function automatic logic [31:0] model_imm(input logic [31:0] i);
    logic [31:0] raw;
    raw = 32'd0;
    case (i[6:0])
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: begin
        raw = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'd0};
        return 32'($signed(raw) >>> 11);
      end
      7'h67, 7'h03, 7'h13: return 32'($signed(i) >>> 20);
      7'h63: begin
        raw = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'd0};
        return 32'($signed(raw) >>> 19);
      end
      7'h23: begin
        raw = {i[31:25], i[11:7], 20'd0};
        return 32'($signed(raw) >>> 20);
      end
      default: return 32'd0;
    endcase
  endfunction

  // Compare process: every falling edge once out of the initial reset.
  always @(negedge clk) begin
    if (checking) begin
      logic [31:0] ei, ep;
      ei = (mq.size() != 0) ? mq[0][63:32] : 32'd0;
      ep = (mq.size() != 0) ? mq[0][31:0]  : 32'd0;
      check("out_valid",  {31'd0, out_valid},  {31'd0, mq.size() != 0});
      check("queue_full", {31'd0, queue_full}, {31'd0, mq.size() == DEPTH});
      check("out_inst",   out_inst, ei);
      check("out_pc",     out_pc,   ep);
      check("out_opcode", {25'd0, out_opcode}, {25'd0, ei[6:0]});
      check("out_rd",     {27'd0, out_rd},     {27'd0, ei[11:7]});
      check("out_rs1",    {27'd0, out_rs1},    {27'd0, ei[19:15]});
      check("out_rs2",    {27'd0, out_rs2},    {27'd0, ei[24:20]});
      check("out_funct3", {29'd0, out_funct3}, {29'd0, ei[14:12]});
      check("out_imm",    out_imm, model_imm(ei));
    end
  end

  // Driver: apply inputs for one cycle, advance the model at the edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ir, input logic jf, input logic r);
    bit pop, push;
    inst_valid  = v;
    inst_in     = inst;
    pc_in       = pc;
    issue_ready = ir;
    jump_flag   = jf;
    rdy         = r;
    @(posedge clk);
    if (r) begin
      if (jf) begin
        mq.delete();
      end else begin
        pop  = (mq.size() != 0) && ir;
        push = v && ((mq.size() < DEPTH) || pop);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back({inst, pc});
      end
    end
    #1;
    inst_valid  = 1'b0;
    issue_ready = 1'b0;
    jump_flag   = 1'b0;
    rdy         = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
  endtask

  logic [31:0] imm_inst [7];
  logic [31:0] imm_exp  [7];

  initial begin
    rst = 1'b0; rdy = 1'b1; inst_valid = 1'b0; inst_in = '0; pc_in = '0;
    jump_flag = 1'b0; issue_ready = 1'b0;
    #2;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_full",  {31'd0, queue_full}, 32'd0);
    check("reset_inst",  out_inst, 32'd0);
    check("reset_imm",   out_imm, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    checking = 1'b1;

    // Single ADDI x1,x0,5 visible the cycle after the push
    step(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_rd",    {27'd0, out_rd}, 32'd1);
    check("addi_rs1",   {27'd0, out_rs1}, 32'd0);
    check("addi_imm",   out_imm, 32'h0000_0005);
    check("addi_pc",    out_pc, 32'h0);
    drain();

    // Fill to 16 with no pops, 17th dropped, then drain in order
    for (int i = 0; i < 17; i++)
      step(1'b1, 32'h1000_0000 + i, 32'h100 + 4 * i, 1'b0, 1'b0, 1'b1);
    check("fill_full", {31'd0, queue_full}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("fifo_order", out_inst, 32'h1000_0000 + i);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    end
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    // Pointers wrapped: next push becomes the head
    step(1'b1, 32'h2222_0013, 32'h40, 1'b0, 1'b0, 1'b1);
    check("wrap_head", out_inst, 32'h2222_0013);
    drain();

    // Full queue with simultaneous push and pop
    for (int i = 0; i < 16; i++)
      step(1'b1, 32'h3000_0000 + i, 32'h200 + 4 * i, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3333_3333, 32'h300, 1'b1, 1'b0, 1'b1);
    check("pp_full", {31'd0, queue_full}, 32'd1);
    check("pp_head", out_inst, 32'h3000_0001);
    for (int i = 0; i < 15; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    check("pp_tail", out_inst, 32'h3333_3333);
    drain();

    // Flush with a same-edge push at count 5
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h4000_0000 + i, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4444_4444, 32'h0, 1'b1, 1'b1, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    idle(1);
    check("flush_nostore", {31'd0, out_valid}, 32'd0);

    // Immediate formats, each alone at the head
    imm_inst[0] = 32'hFE00_0EE3; imm_exp[0] = 32'hFFFF_FFFC; // beq x0,x0,-4
    imm_inst[1] = 32'h0000_006F; imm_exp[1] = 32'h0000_0000; // jal x0,0
    imm_inst[2] = 32'h0080_006F; imm_exp[2] = 32'h0000_0008; // jal x0,8
    imm_inst[3] = 32'h1234_50B7; imm_exp[3] = 32'h1234_5000; // lui
    imm_inst[4] = 32'hFE11_2E23; imm_exp[4] = 32'hFFFF_FFFC; // sw x1,-4(x2)
    imm_inst[5] = 32'hFFC1_2083; imm_exp[5] = 32'hFFFF_FFFC; // lw x1,-4(x2)
    imm_inst[6] = 32'h0020_81B3; imm_exp[6] = 32'h0000_0000; // add
    for (int i = 0; i < 7; i++) begin
      step(1'b1, imm_inst[i], 32'h500 + 4 * i, 1'b0, 1'b0, 1'b1);
      check("imm_literal", out_imm, imm_exp[i]);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    end

    // rdy low freezes everything
    step(1'b1, 32'h5555_0013, 32'h600, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h5556_0013, 32'h604, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h5557_0013, 32'h608, 1'b1, 1'b0, 1'b0);
      check("stall_head", out_inst, 32'h5555_0013);
      check("stall_pc",   out_pc, 32'h600);
    end
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    check("stall_second", out_inst, 32'h5556_0013);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    check("stall_count", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h6000_0000 + i, 32'h700, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    mq.delete();
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_inst",  out_inst, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, 32'h7777_0013, 32'h800, 1'b0, 1'b0, 1'b1);
    check("post_reset_head", out_inst, 32'h7777_0013);
    drain();

    @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, setting the number of queue entries (power of two, at least 4).
REQ-002 The block SHALL have parameter ADDR_W, default 4, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; asynchronous and active-low.
REQ-005 The block SHALL have port rdy, input, 1 bit; when low, all state SHALL freeze.
REQ-006 The block SHALL have port inst_valid, input, 1 bit, push request from instruction fetch.
REQ-007 The block SHALL have port inst_in, input, 32 bits, the fetched instruction.
REQ-008 The block SHALL have port pc_in, input, 32 bits, the PC of inst_in.
REQ-009 The block SHALL have port queue_full, output, 1 bit, back-pressure to fetch.
REQ-010 The block SHALL have port jump_flag, input, 1 bit, pipeline flush from the reorder buffer.
REQ-011 The block SHALL have port issue_ready, input, 1 bit; the issue stage accepts the head entry.
REQ-012 The block SHALL have port out_valid, output, 1 bit; the head entry is present.
REQ-013 The block SHALL have port out_inst, output, 32 bits, the head instruction.
REQ-014 The block SHALL have port out_pc, output, 32 bits, the head PC.
REQ-015 The block SHALL have port out_opcode, output, 7 bits, bits [6:0] of the head instruction.
REQ-016 The block SHALL have ports out_rd, out_rs1 and out_rs2, outputs, 5 bits each: bits [11:7], [19:15] and [24:20].
REQ-017 The block SHALL have port out_funct3, output, 3 bits, bits [14:12] of the head instruction.
REQ-018 The block SHALL have port out_imm, output, 32 bits, the sign-extended immediate of the head instruction.

Function
REQ-019 The block SHALL be a circular FIFO with head and tail pointers of ADDR_W bits that wrap modulo DEPTH, and a count of ADDR_W+1 bits in the range 0..DEPTH.
REQ-020 A push SHALL occur on an edge where inst_valid=1 and (count<DEPTH, or a pop occurs on the same edge); otherwise the input SHALL be dropped.
REQ-021 A pop SHALL occur on an edge where out_valid=1 and issue_ready=1.
REQ-022 When push and pop occur on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 There SHALL be no bypass: a word pushed at edge N SHALL appear at the outputs no earlier than after edge N, even if the queue was empty.
REQ-024 out_valid SHALL equal (count!=0), and queue_full SHALL equal (count==DEPTH); both are combinational from registered state.
REQ-025 out_inst, out_pc and all decoded fields SHALL be combinational from the head entry; they SHALL be 0 when count==0.
REQ-026 out_imm SHALL be selected by opcode:
- 0110111 / 0010111 (U-type): {inst[31:12], 12'b0}
- 1101111 (J-type): sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
- 1100111, 0000011, 0010011 (I-type): sext(inst[31:20])
- 1100011 (B-type): sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
- 0100011 (S-type): sext({inst[31:25], inst[11:7]})
- all other opcodes: 0
REQ-027 jump_flag=1 at an edge (with rdy=1) SHALL clear head, tail and count to 0; any same-edge push or pop SHALL be ignored.
REQ-028 With rdy=0, no push, pop or flush SHALL occur; outputs SHALL hold their values.
REQ-029 Entry storage need not be reset; only the pointers and count are state-bearing.

Reset
REQ-030 While rst=0, head, tail and count SHALL be 0 immediately, without waiting for a clock edge, giving out_valid=0, queue_full=0 and all data outputs 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL become the head.

Verification
REQ-032 Reset, then push inst 0x00500093 with pc 0x0 -> out_valid=1 on the next cycle; out_rd=1, out_rs1=0, out_imm=0x00000005, out_pc=0x0.
REQ-033 Push 16 words with issue_ready=0 -> queue_full=1; a 17th push is dropped; pop all 16 -> the words come out in original order and the pointers wrap to 0.
REQ-034 At count=16, push and pop on the same edge -> count stays 16, the new word lands at the tail, and queue_full stays 1.
REQ-035 With count=5, assert jump_flag together with inst_valid -> count=0 and out_valid=0 next cycle; the new word is not stored.
REQ-036 Head 0xFE000EE3 (BEQ x0,x0,-4) -> out_imm=0xFFFFFFFC; head 0x0000006F (JAL x0,0) -> out_imm=0.
REQ-037 Hold rdy=0 for 3 cycles while driving inst_valid and issue_ready -> count and outputs are unchanged.
